// File: rtl/fuzzify_seq.sv
// Fuzzification sequencer: holds a trapezoid MF breakpoint table and streams it,
// one MF per cycle, through an external combinational trapezoid unit, tracking the peak mu.
module fuzzify_seq #(
  parameter int N_MF  = 7,
  parameter int IDX_W = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic signed [7:0]       x_in,
  input  logic                    cfg_we,
  input  logic [IDX_W-1:0]        cfg_idx,
  input  logic signed [7:0]       cfg_a,
  input  logic signed [7:0]       cfg_b,
  input  logic signed [7:0]       cfg_c,
  input  logic signed [7:0]       cfg_d,
  output logic                    cfg_err,
  output logic signed [7:0]       tz_x,
  output logic signed [7:0]       tz_a,
  output logic signed [7:0]       tz_b,
  output logic signed [7:0]       tz_c,
  output logic signed [7:0]       tz_d,
  input  logic [15:0]             tz_mu,
  output logic                    busy,
  output logic                    mu_valid,
  output logic [IDX_W-1:0]        mu_idx,
  output logic [15:0]             mu_out,
  output logic                    done,
  output logic [IDX_W-1:0]        peak_idx,
  output logic [15:0]             peak_mu
);

  localparam int DATA_W = 8;
  localparam int MU_W   = 16;
  localparam int DEPTH  = 2**IDX_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_MF - 1);
  localparam logic [IDX_W-1:0] IDX0     = '0;

  typedef enum logic {IDLE, ISSUE} state_t;

  function automatic logic bp_ordered(input logic signed [DATA_W-1:0] a,
                                      input logic signed [DATA_W-1:0] b,
                                      input logic signed [DATA_W-1:0] c,
                                      input logic signed [DATA_W-1:0] d);
    return (a <= b) && (b <= c) && (c <= d);
  endfunction

  // Strict compare so that ties keep the earlier (lower) index.
  function automatic logic mu_beats(input logic [MU_W-1:0] cand,
                                    input logic [MU_W-1:0] best);
    return cand > best;
  endfunction

  state_t state, state_nxt;
  logic [IDX_W-1:0] cnt;
  logic [IDX_W-1:0] cnt_inc;
  logic frame_go;
  logic issuing;
  logic last_issue;
  logic cfg_ok;
  logic cfg_rej;

  logic signed [DATA_W-1:0] mf_a [DEPTH];
  logic signed [DATA_W-1:0] mf_b [DEPTH];
  logic signed [DATA_W-1:0] mf_c [DEPTH];
  logic signed [DATA_W-1:0] mf_d [DEPTH];

  assign busy    = (state == ISSUE);
  assign issuing = (state == ISSUE);
  assign cnt_inc = cnt + 1'b1;

  // Table writes only land while idle and not racing a frame launch.
  assign cfg_ok  = cfg_we && (state == IDLE) && !start && (cfg_idx <= LAST_IDX) &&
                   bp_ordered(cfg_a, cfg_b, cfg_c, cfg_d);
  assign cfg_rej = cfg_we && !cfg_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    frame_go   = 1'b0;
    last_issue = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          frame_go  = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (cnt == LAST_IDX) begin
          last_issue = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      mu_valid <= 1'b0;
      done     <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      cfg_err  <= cfg_rej;
      mu_valid <= issuing;
      done     <= last_issue;
      if (frame_go)        cnt <= '0;
      else if (last_issue) cnt <= '0;
      else if (issuing)    cnt <= cnt_inc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mf_a[i] <= '0;
        mf_b[i] <= '0;
        mf_c[i] <= '0;
        mf_d[i] <= '0;
      end
    end else if (cfg_ok) begin
      mf_a[cfg_idx] <= cfg_a;
      mf_b[cfg_idx] <= cfg_b;
      mf_c[cfg_idx] <= cfg_c;
      mf_d[cfg_idx] <= cfg_d;
    end
  end

  // Operand issue / result capture: tz_mu seen at edge Ek belongs to MF[k-1].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tz_x     <= '0;
      tz_a     <= '0;
      tz_b     <= '0;
      tz_c     <= '0;
      tz_d     <= '0;
      mu_out   <= '0;
      mu_idx   <= '0;
      peak_mu  <= '0;
      peak_idx <= '0;
    end else if (frame_go) begin
      tz_x     <= x_in;
      tz_a     <= mf_a[IDX0];
      tz_b     <= mf_b[IDX0];
      tz_c     <= mf_c[IDX0];
      tz_d     <= mf_d[IDX0];
      peak_mu  <= '0;
      peak_idx <= '0;
    end else if (issuing) begin
      mu_out <= tz_mu;
      mu_idx <= cnt;
      if (!last_issue) begin
        tz_a <= mf_a[cnt_inc];
        tz_b <= mf_b[cnt_inc];
        tz_c <= mf_c[cnt_inc];
        tz_d <= mf_d[cnt_inc];
      end
      if (mu_beats(tz_mu, peak_mu)) begin
        peak_mu  <= tz_mu;
        peak_idx <= cnt;
      end
    end
  end

endmodule

// File: tb/tb_fuzzify_seq.sv
// Bench for fuzzify_seq with N_MF=3: models the external trapezoid unit and
// scoreboards every mu_valid result against a shadow copy of the MF table.
module tb_fuzzify_seq;

  localparam int N = 3;

  typedef struct {
    logic [1:0]  idx;
    logic [15:0] mu;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic signed [7:0] x_in = '0;
  logic cfg_we = 1'b0;
  logic [1:0] cfg_idx = '0;
  logic signed [7:0] cfg_a = '0, cfg_b = '0, cfg_c = '0, cfg_d = '0;
  logic cfg_err;
  logic signed [7:0] tz_x, tz_a, tz_b, tz_c, tz_d;
  logic [15:0] tz_mu;
  logic busy, mu_valid, done;
  logic [1:0] mu_idx, peak_idx;
  logic [15:0] mu_out, peak_mu;
  logic [78:0] outs;

  logic signed [7:0] sh_a [4];
  logic signed [7:0] sh_b [4];
  logic signed [7:0] sh_c [4];
  logic signed [7:0] sh_d [4];
  exp_t sb[$];
  int vec_cnt = 0;
  int err_cnt = 0;

  fuzzify_seq #(.N_MF(N), .IDX_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .x_in(x_in),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_a(cfg_a), .cfg_b(cfg_b), .cfg_c(cfg_c), .cfg_d(cfg_d),
    .cfg_err(cfg_err),
    .tz_x(tz_x), .tz_a(tz_a), .tz_b(tz_b), .tz_c(tz_c), .tz_d(tz_d),
    .tz_mu(tz_mu), .busy(busy), .mu_valid(mu_valid), .mu_idx(mu_idx),
    .mu_out(mu_out), .done(done), .peak_idx(peak_idx), .peak_mu(peak_mu)
  );

  always #5 clk = ~clk;

  // Reference trapezoid: 0 outside [a,d], 1.0 (0x8000) on [b,c], linear ramps between.
  function automatic logic [15:0] trap(input logic signed [7:0] x, a, b, c, d);
    int xi, ai, bi, ci, di;
    xi = x; ai = a; bi = b; ci = c; di = d;
    if (xi < ai || xi > di) return 16'h0000;
    if (xi >= bi && xi <= ci) return 16'h8000;
    if (xi < bi) return 16'((xi - ai) * 32768 / (bi - ai));
    return 16'((di - xi) * 32768 / (di - ci));
  endfunction

  assign tz_mu = trap(tz_x, tz_a, tz_b, tz_c, tz_d);
  assign outs  = {busy, mu_valid, done, cfg_err, mu_out, mu_idx, peak_mu, peak_idx,
                  tz_x, tz_a, tz_b, tz_c, tz_d};

  function automatic void push_frame(input logic signed [7:0] x);
    exp_t e;
    for (int k = 0; k < N; k++) begin
      e.idx = 2'(k);
      e.mu  = trap(x, sh_a[k], sh_b[k], sh_c[k], sh_d[k]);
      sb.push_back(e);
    end
  endfunction

  function automatic exp_t exp_peak(input logic signed [7:0] x);
    exp_t best;
    logic [15:0] m;
    best.idx = '0;
    best.mu  = '0;
    for (int k = 0; k < N; k++) begin
      m = trap(x, sh_a[k], sh_b[k], sh_c[k], sh_d[k]);
      if (m > best.mu) begin
        best.idx = 2'(k);
        best.mu  = m;
      end
    end
    return best;
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic signed [7:0] x);
    x_in  = x;
    start = 1'b1;
    push_frame(x);
    step;
    start = 1'b0;
  endtask

  task automatic cfg_write(input logic [1:0] i, input logic signed [7:0] a, b, c, d,
                           input logic ok, output logic err);
    cfg_idx = i; cfg_a = a; cfg_b = b; cfg_c = c; cfg_d = d;
    cfg_we  = 1'b1;
    step;
    err    = cfg_err;
    cfg_we = 1'b0;
    if (ok) begin
      sh_a[i] = a; sh_b[i] = b; sh_c[i] = c; sh_d[i] = d;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #3;
    vec_cnt++;
    if (outs !== '0) begin
      err_cnt++; $display("FAIL reset_outs got %h want 0", outs);
    end
    step; step;
    rst_n = 1'b1;
    step;
    vec_cnt++;
    if (outs !== '0) begin
      err_cnt++; $display("FAIL reset_release got %h want 0", outs);
    end
  endtask

  task automatic test_load;
    logic e;
    cfg_write(2'd0, -8'sd64, 8'sd0, 8'sd0, 8'sd64, 1'b1, e);
    vec_cnt++;
    if (e !== 1'b0) begin err_cnt++; $display("FAIL load_mf0 got %b want 0", e); end
    cfg_write(2'd1, -8'sd64, -8'sd16, 8'sd16, 8'sd64, 1'b1, e);
    vec_cnt++;
    if (e !== 1'b0) begin err_cnt++; $display("FAIL load_mf1 got %b want 0", e); end
    cfg_write(2'd2, 8'sd32, 8'sd48, 8'sd64, 8'sd96, 1'b1, e);
    vec_cnt++;
    if (e !== 1'b0) begin err_cnt++; $display("FAIL load_mf2 got %b want 0", e); end
  endtask

  task automatic test_basic;
    exp_t pk;
    pk = exp_peak(-8'sd32);
    launch(-8'sd32);
    vec_cnt++;
    if ({busy, mu_valid, done} !== 3'b100) begin
      err_cnt++; $display("FAIL basic_e0 got %b want 100", {busy, mu_valid, done});
    end
    for (int c = 1; c <= N; c++) begin
      step;
      vec_cnt++;
      if ({mu_valid, mu_idx, done} !== {1'b1, 2'(c - 1), c == N}) begin
        err_cnt++;
        $display("FAIL basic_ctl c=%0d got %b want %b", c, {mu_valid, mu_idx, done},
                 {1'b1, 2'(c - 1), c == N});
      end
      vec_cnt++;
      if ((c == 1 && (mu_out < 16'h3E00 || mu_out > 16'h4200)) ||
          (c == 2 && (mu_out < 16'h5400 || mu_out > 16'h5A00)) ||
          (c == 3 && mu_out !== 16'h0000)) begin
        err_cnt++; $display("FAIL basic_range c=%0d got %h", c, mu_out);
      end
    end
    vec_cnt++;
    if ({peak_idx, peak_mu} !== {2'd1, pk.mu}) begin
      err_cnt++; $display("FAIL basic_peak got %0d/%h want 1/%h", peak_idx, peak_mu, pk.mu);
    end
    step;
    vec_cnt++;
    if ({busy, mu_valid, done, mu_idx, mu_out, peak_idx} !== {3'b000, 2'd2, 16'h0000, 2'd1}) begin
      err_cnt++; $display("FAIL basic_hold got %h", {busy, mu_valid, done, mu_idx, mu_out, peak_idx});
    end
  endtask

  task automatic test_tie;
    launch(8'sd0);
    for (int c = 1; c <= N; c++) begin
      step;
      if (c < N) begin
        vec_cnt++;
        if (mu_out < 16'h7F00) begin
          err_cnt++; $display("FAIL tie_mu c=%0d got %h want >=7f00", c, mu_out);
        end
      end
    end
    vec_cnt++;
    if ({done, peak_idx} !== {1'b1, 2'd0} || peak_mu < 16'h7F00) begin
      err_cnt++; $display("FAIL tie_peak got done=%b idx=%0d mu=%h want 1/0/>=7f00", done, peak_idx, peak_mu);
    end
    step;
  endtask

  task automatic test_cfg_err;
    logic e;
    cfg_write(2'd0, 8'sd10, 8'sd5, 8'sd20, 8'sd30, 1'b0, e);
    vec_cnt++;
    if (e !== 1'b1) begin err_cnt++; $display("FAIL err_nonmono got %b want 1", e); end
    step;
    vec_cnt++;
    if (cfg_err !== 1'b0) begin err_cnt++; $display("FAIL err_pulse got %b want 0", cfg_err); end
    cfg_write(2'd3, 8'sd0, 8'sd0, 8'sd0, 8'sd0, 1'b0, e);
    vec_cnt++;
    if (e !== 1'b1) begin err_cnt++; $display("FAIL err_idx got %b want 1", e); end
    // write racing start, then a write while the frame is busy
    x_in = -8'sd32; start = 1'b1; push_frame(x_in);
    cfg_idx = 2'd1; cfg_a = '0; cfg_b = '0; cfg_c = '0; cfg_d = '0; cfg_we = 1'b1;
    step;
    start = 1'b0; cfg_idx = 2'd0;
    vec_cnt++;
    if ({cfg_err, busy} !== 2'b11) begin
      err_cnt++; $display("FAIL err_start got %b want 11", {cfg_err, busy});
    end
    step;
    cfg_we = 1'b0;
    vec_cnt++;
    if (cfg_err !== 1'b1) begin err_cnt++; $display("FAIL err_busy got %b want 1", cfg_err); end
    step; step; step;
    launch(-8'sd32);
    step; step; step;
    vec_cnt++;
    if ({done, peak_idx} !== {1'b1, 2'd1}) begin
      err_cnt++; $display("FAIL err_readback got %b want 101", {done, peak_idx});
    end
    step;
  endtask

  task automatic test_back_to_back;
    x_in = -8'sd32; start = 1'b1; push_frame(x_in);
    step;
    for (int c = 1; c <= 12; c++) begin
      step;
      if (c == 4) push_frame(x_in);
      if (c == 8) begin push_frame(x_in); start = 1'b0; end
      vec_cnt++;
      if ({mu_valid, done, busy} !== {c % 4 != 0, c % 4 == 3, (c % 4 != 3) && (c < 12)}) begin
        err_cnt++;
        $display("FAIL b2b c=%0d got %b want %b", c, {mu_valid, done, busy},
                 {c % 4 != 0, c % 4 == 3, (c % 4 != 3) && (c < 12)});
      end
    end
    launch(8'sd0);
    for (int c = 1; c <= N + 2; c++) begin
      start = (c <= N) ? 1'(c % 2) : 1'b0;
      step;
      vec_cnt++;
      if ({mu_valid, busy} !== {c <= N, c < N}) begin
        err_cnt++; $display("FAIL busy_start c=%0d got %b want %b", c, {mu_valid, busy}, {c <= N, c < N});
      end
    end
  endtask

  task automatic test_midframe;
    launch(-8'sd32);
    x_in = 8'sd0;
    for (int c = 1; c <= N; c++) begin
      step;
      x_in = 8'(c * 17);
      vec_cnt++;
      if (tz_x !== -8'sd32) begin
        err_cnt++; $display("FAIL mid_tzx c=%0d got %0d want -32", c, tz_x);
      end
    end
    step;
  endtask

  task automatic test_reset_mid;
    launch(-8'sd32);
    step; step;
    rst_n = 1'b0;
    #1;
    vec_cnt++;
    if (outs !== '0) begin err_cnt++; $display("FAIL rstmid_outs got %h want 0", outs); end
    sb.delete();
    for (int k = 0; k < 4; k++) begin
      sh_a[k] = '0; sh_b[k] = '0; sh_c[k] = '0; sh_d[k] = '0;
    end
    step;
    vec_cnt++;
    if (outs !== '0) begin err_cnt++; $display("FAIL rstmid_hold got %h want 0", outs); end
    rst_n = 1'b1;
    step;
    launch(8'sd0);
    for (int c = 1; c <= N; c++) begin
      step;
      vec_cnt++;
      if (mu_out < 16'h7F00) begin
        err_cnt++; $display("FAIL zero_tab_x0 c=%0d got %h want >=7f00", c, mu_out);
      end
    end
    step;
    launch(8'sd5);
    for (int c = 1; c <= N; c++) begin
      step;
      vec_cnt++;
      if (mu_out !== 16'h0000) begin
        err_cnt++; $display("FAIL zero_tab_x5 c=%0d got %h want 0", c, mu_out);
      end
    end
    step;
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      sh_a[k] = '0; sh_b[k] = '0; sh_c[k] = '0; sh_d[k] = '0;
    end
    fork
      forever begin
        @(negedge clk);
        if (mu_valid === 1'b1) begin
          vec_cnt++;
          if (sb.size() == 0) begin
            err_cnt++; $display("FAIL sb_unexpected got idx=%0d mu=%h want none", mu_idx, mu_out);
          end else begin
            exp_t e;
            e = sb.pop_front();
            if ({mu_idx, mu_out} !== {e.idx, e.mu}) begin
              err_cnt++;
              $display("FAIL sb_mu got idx=%0d mu=%h want idx=%0d mu=%h", mu_idx, mu_out, e.idx, e.mu);
            end
          end
        end
      end
    join_none
    test_reset;
    test_load;
    test_basic;
    test_tie;
    test_cfg_err;
    test_back_to_back;
    test_midframe;
    test_reset_mid;
    step;
    vec_cnt++;
    if (sb.size() != 0) begin
      err_cnt++; $display("FAIL sb_leftover got %0d want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/fuzzify_seq.md
FUZZIFY_SEQ -- requirements
Module: fuzzify_seq

Interface
REQ-001 SHALL have parameter N_MF, default 7, meaning number of membership functions (MFs) in the table; legal range 2..16.
REQ-002 SHALL have parameter IDX_W, default 4, meaning index width; must satisfy 2**IDX_W >= N_MF.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 start  in  1  request one fuzzification frame.
REQ-006 x_in  in  8  crisp input, signed Q7.0.
REQ-007 cfg_we  in  1  MF table write strobe.
REQ-008 cfg_idx  in  IDX_W  MF index to write.
REQ-009 cfg_a, cfg_b, cfg_c, cfg_d  in  8 each  breakpoints, signed Q7.0.
REQ-010 cfg_err  out  1  one-cycle pulse when a write is rejected.
REQ-011 tz_x, tz_a, tz_b, tz_c, tz_d  out  8 each  registered operands to the external combinational trapezoid MF unit.
REQ-012 tz_mu  in  16  unsigned Q1.15 result from the trapezoid unit.
REQ-013 busy  out  1  high while a frame is being issued.
REQ-014 mu_valid  out  1  mu_out and mu_idx are valid this cycle.
REQ-015 mu_idx  out  IDX_W  MF index of mu_out.
REQ-016 mu_out  out  16  captured degree of membership, Q1.15.
REQ-017 done  out  1  one-cycle pulse marking the end of a frame.
REQ-018 peak_idx  out  IDX_W  index of the largest mu in the last frame.
REQ-019 peak_mu  out  16  value of the largest mu in the last frame.

Function
REQ-020 FSM states SHALL be IDLE and ISSUE; an issue counter SHALL run 0..N_MF-1.
REQ-021 In IDLE, start=1 at edge E0 SHALL do all of the following: latch x_in into tz_x; load MF[0] into tz_a..tz_d; enter ISSUE; clear peak_mu and peak_idx to 0.
REQ-022 At edge Ek (k=1..N_MF) the block SHALL do all of the following:
- capture tz_mu into mu_out;
- set mu_idx=k-1 and mu_valid=1;
- for k<N_MF, load MF[k] into tz_a..tz_d.
REQ-023 At edge E_N_MF the FSM SHALL return to IDLE and pulse done=1, coincident with the last mu_valid.
REQ-024 Timing SHALL satisfy: latency from start to first mu_valid is 1 cycle; one result per cycle; no gaps; frame period N_MF+1 cycles.
REQ-025 busy SHALL equal (state==ISSUE).
REQ-026 start while busy SHALL be ignored; frames are never queued.
REQ-027 tz_x SHALL be held constant for the whole frame, regardless of later x_in changes.
REQ-028 On each mu_valid, if mu_out > peak_mu (unsigned, strict), then peak_mu and peak_idx SHALL update; ties keep the lowest index; final values are valid from the done cycle until the next start.
REQ-029 mu_valid and done SHALL be 0 outside the stated cycles; mu_out, mu_idx and tz_* SHALL hold their last values.
REQ-030 A write SHALL be accepted only in IDLE, with start=0, cfg_idx<N_MF and cfg_a<=cfg_b<=cfg_c<=cfg_d (signed); an accepted write stores into MF[cfg_idx] at that edge.
REQ-031 Any other cfg_we=1 SHALL pulse cfg_err for 1 cycle and leave the table unchanged; this covers writes while busy, writes with simultaneous start, out-of-range index and non-monotonic breakpoints.
REQ-032 Writes never alter the tz_* values of a frame in progress.

Reset
REQ-033 While rst_n=0 the block SHALL hold these values: state=IDLE; counter=0; busy=0; mu_valid=0; done=0; cfg_err=0; mu_out=0; mu_idx=0; peak_mu=0; peak_idx=0; tz_*=0; every MF entry a=b=c=d=0.
REQ-034 Reset mid-frame SHALL abort the frame with no done pulse; operation resumes at IDLE on the first edge after rst_n rises.

Verification
REQ-035 Bench: load MF0=(-64,0,0,64), MF1=(-64,-16,16,64), MF2=(32,48,64,96), with N_MF=3; start with x_in=-32 -> mu_valid for idx 0,1,2 on cycles 1,2,3; mu0 in 0x3E00..0x4200; mu1 in 0x5400..0x5A00; mu2=0; done on cycle 3; peak_idx=1.
REQ-036 Bench: same table, x_in=0 -> mu0>=0x7F00 and mu1>=0x7F00; tie keeps peak_idx=0.
REQ-037 Bench: cfg writes (10,5,20,30), idx=N_MF, and any write during busy -> each produces a cfg_err pulse; read-back via a later frame shows an unchanged table.
REQ-038 Bench: start held high continuously -> frames every N_MF+1 cycles; start pulses during busy produce no extra mu_valid.
REQ-039 Bench: change x_in mid-frame -> remaining results computed with the latched x.
REQ-040 Bench: assert rst_n=0 at cycle 2 of a frame -> all outputs 0 immediately, no done; a new frame after release works with an all-zero table (x_in=0 gives mu>=0x7F00 for every idx; x_in=5 gives 0).
